// File: rtl/s3g_tx_arbiter.sv
// rtl/s3g_tx_arbiter.sv - two-slot packet arbiter in front of the s3g_tx transmitter
module s3g_tx_arbiter #(
  parameter bit FIXED_PRIO   = 1'b0,
  parameter int MAX_LEN      = 16,
  parameter int BUSY_TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a_wr,
  input  logic [7:0]   req_a_len,
  input  logic [127:0] req_a_data,
  output logic         req_a_busy,
  input  logic         req_b_wr,
  input  logic [7:0]   req_b_len,
  input  logic [127:0] req_b_data,
  output logic         req_b_busy,
  input  logic         tx_busy,
  output logic         tx_packet_wr,
  output logic [7:0]   tx_payload_len,
  output logic [127:0] tx_data,
  output logic [1:0]   tx_owner,
  output logic [7:0]   drop_cnt_a,
  output logic [7:0]   drop_cnt_b,
  output logic         timeout_err
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t         state, state_d;
  logic [TW-1:0]  busy_cnt, busy_cnt_d;
  logic [7:0]     slot_a_len, slot_b_len;
  logic [127:0]   slot_a_data, slot_b_data;
  logic           last_grant_b;
  logic           launch_a, launch_b, release_tx, to_expire;

  function automatic logic [7:0] clamp_len(input logic [7:0] len);
    return (len > MAX_LEN_B) ? MAX_LEN_B : len;
  endfunction

  // last_grant_b = 1 means B was served last, so A wins the next tie
  always_comb begin
    state_d    = state;
    busy_cnt_d = busy_cnt;
    launch_a   = 1'b0;
    launch_b   = 1'b0;
    release_tx = 1'b0;
    to_expire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_a_busy && (!req_b_busy || FIXED_PRIO || last_grant_b)) begin
          launch_a = 1'b1;
          state_d  = S_DELAY;
        end else if (req_b_busy) begin
          launch_b = 1'b1;
          state_d  = S_DELAY;
        end
      end
      S_DELAY: begin
        state_d    = S_BUSY;
        busy_cnt_d = '0;
      end
      S_BUSY: begin
        if (!tx_busy) begin
          release_tx = 1'b1;
          state_d    = S_IDLE;
        end else if (BUSY_TIMEOUT > 0) begin
          if (busy_cnt == TO_LAST) begin
            to_expire  = 1'b1;
            release_tx = 1'b1;
            state_d    = S_IDLE;
          end else begin
            busy_cnt_d = busy_cnt + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      busy_cnt <= '0;
    end else begin
      state    <= state_d;
      busy_cnt <= busy_cnt_d;
    end
  end

  // A strobe in the launch cycle still sees the slot full and counts as a drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_a_busy  <= 1'b0;
      slot_a_len  <= '0;
      slot_a_data <= '0;
      drop_cnt_a  <= '0;
    end else begin
      if (launch_a) begin
        req_a_busy <= 1'b0;
      end else if (req_a_wr && !req_a_busy) begin
        req_a_busy  <= 1'b1;
        slot_a_len  <= clamp_len(req_a_len);
        slot_a_data <= req_a_data;
      end
      if (req_a_wr && req_a_busy && drop_cnt_a != 8'hFF)
        drop_cnt_a <= drop_cnt_a + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_b_busy  <= 1'b0;
      slot_b_len  <= '0;
      slot_b_data <= '0;
      drop_cnt_b  <= '0;
    end else begin
      if (launch_b) begin
        req_b_busy <= 1'b0;
      end else if (req_b_wr && !req_b_busy) begin
        req_b_busy  <= 1'b1;
        slot_b_len  <= clamp_len(req_b_len);
        slot_b_data <= req_b_data;
      end
      if (req_b_wr && req_b_busy && drop_cnt_b != 8'hFF)
        drop_cnt_b <= drop_cnt_b + 8'd1;
    end
  end

  // Payload registers hold the last launch; consumers sample only on tx_packet_wr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_packet_wr   <= 1'b0;
      tx_payload_len <= '0;
      tx_data        <= '0;
      tx_owner       <= 2'd0;
      last_grant_b   <= 1'b1;
      timeout_err    <= 1'b0;
    end else begin
      tx_packet_wr <= launch_a | launch_b;
      if (launch_a) begin
        tx_payload_len <= slot_a_len;
        tx_data        <= slot_a_data;
        tx_owner       <= 2'd1;
        last_grant_b   <= 1'b0;
      end else if (launch_b) begin
        tx_payload_len <= slot_b_len;
        tx_data        <= slot_b_data;
        tx_owner       <= 2'd2;
        last_grant_b   <= 1'b1;
      end else if (release_tx) begin
        tx_owner <= 2'd0;
      end
      if (to_expire)
        timeout_err <= 1'b1;
    end
  end

endmodule
